ats21_cmd_arbiter: RTL and testbench
====================================

Name: ats21_cmd_arbiter

Overview:
- Front-end controller for the ATS21 multi-clock/alarm unit; lets two independent clients (A and B) share its single req/ctrlA/ctrlB/ready command port.
- Each client has a small command FIFO. A round-robin arbiter picks one command at a time and sequences the ATS21 handshake.
- The captured stat/data is routed back to the client that issued the command; a watchdog converts a missing ats_ready into a timeout response.

Parameters:
- FIFO_DEPTH, 4, entries per client command FIFO; power of 2, minimum 2.
- TIMEOUT_CYCLES, 64, WAIT cycles without ats_ready before the command is aborted; range 1 to 255.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- a_valid  in  1  client A command valid.
- a_ready  out  1  client A FIFO can accept; equals !fullA.
- a_ctrlA  in  16  client A command word A.
- a_ctrlB  in  16  client A command word B.
- b_valid, b_ready, b_ctrlA, b_ctrlB  same as the client A set, for client B.
- a_rsp_valid  out  1  one-cycle response pulse to client A.
- a_rsp_stat  out  2  ATS21 stat for client A's command.
- a_rsp_data  out  24  ATS21 data for client A's command.
- a_rsp_timeout  out  1  response was produced by timeout.
- b_rsp_valid, b_rsp_stat, b_rsp_data, b_rsp_timeout  same as the client A set, for client B.
- ats_req  out  1  request strobe to ATS21.
- ats_ctrlA  out  16  command word A to ATS21.
- ats_ctrlB  out  16  command word B to ATS21.
- ats_ready  in  1  ATS21 completion.
- ats_stat  in  2  ATS21 status.
- ats_data  in  24  ATS21 data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (reset=0, async):
  - FIFOs empty; FSM=IDLE; last_grant=B, so A wins the first contention.
  - Timeout counter=0.
  - All outputs 0, except a_ready and b_ready, which are 1.
- FIFO rules:
  - A push occurs when valid && ready on a posedge.
  - ready = !full. A push is never accepted while full, even if a pop happens in the same cycle.
  - Ordering is first-in first-out per client. Read and write pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
- FSM states are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - If exactly one FIFO is non-empty, grant that client.
  - If both are non-empty, grant the client that is not last_grant.
  - On a grant: pop the head into cmd registers, record grant_id, update last_grant, go to ISSUE.
  - If both FIFOs are empty, stay in IDLE.
- ISSUE:
  - ats_req=1 for exactly one cycle; ats_ctrlA/ats_ctrlB driven from the cmd registers.
  - ats_ready is ignored in this state.
  - Next state is WAIT; the timeout counter clears to 0.
- WAIT:
  - ats_req=0; ats_ctrlA/B stay stable until the FSM leaves RESP.
  - If ats_ready=1 is sampled: capture ats_stat/ats_data, set timeout_flag=0, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 with ats_ready still 0: capture stat=0 and data=0, set timeout_flag=1, go to RESP.
  - If ats_ready and timeout occur in the same cycle, ready wins.
- RESP:
  - Drive the captured values on the granted client's rsp bus with rsp_valid=1 for one cycle. Responses have no backpressure.
  - The other client's rsp_valid stays 0. rsp_stat/data/timeout outputs hold their last values between pulses.
  - Next state is IDLE.
- Latency: command accepted at edge t → arbitrated at t+1 → ats_req high in cycle t+2. If ats_ready is sampled at edge k, rsp_valid is high in cycle k+1. Minimum back-to-back command spacing is 4 cycles.
- Pushes into either FIFO continue during ISSUE, WAIT and RESP.
- busy = (state != IDLE).
- Reset asserted mid-operation: the outstanding command is dropped with no response, and all queued commands are discarded.

Test Plan:
1. Single command: A pushes ctrlA=16'h1234, ctrlB=16'h0005; ats_ready=1 with stat=2'b01, data=24'h00000F three cycles after ats_req. Expect ats_req one cycle at t+2 with 1234/0005, then a_rsp_valid one cycle with stat 01, data 00000F, timeout 0. b_rsp_valid stays 0.
2. Contention: A and B each push 2 commands (A1, A2, B1, B2) in the same cycles. Expect issue order A1, B1, A2, B2, with each response returned only to its originator.
3. FIFO full: with ats_ready held 0, A pushes 6 commands. Expect a_ready=0 after 4 entries are stored plus 1 popped, so 5 accepted in total. The 6th command is held until a slot frees.
4. Timeout: TIMEOUT_CYCLES=8, ats_ready never asserted. Expect a_rsp_valid with timeout=1, stat=0, data=0 exactly 9 cycles after ats_req; the next queued command then issues normally.
5. Simultaneous ready and timeout: ats_ready=1 on the final timeout cycle. Expect a normal response with timeout=0.
6. Reset mid-WAIT: reset pulsed low while in WAIT with 2 commands queued. Expect all outputs reset immediately (asynchronously), no rsp_valid, busy=0, and FIFOs empty.

Source files
------------

// File: rtl/ats21_cmd_arbiter_if.sv
// Command, response and ATS21-side signals of the two-client ATS21 command arbiter.
// The arbiter uses the slave modport; the client/ATS21 side uses master.
interface ats21_cmd_arbiter_if;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] a_ctrlA;
    logic [15:0] a_ctrlB;
    logic        b_valid;
    logic        b_ready;
    logic [15:0] b_ctrlA;
    logic [15:0] b_ctrlB;

    logic        a_rsp_valid;
    logic [1:0]  a_rsp_stat;
    logic [23:0] a_rsp_data;
    logic        a_rsp_timeout;
    logic        b_rsp_valid;
    logic [1:0]  b_rsp_stat;
    logic [23:0] b_rsp_data;
    logic        b_rsp_timeout;

    logic        ats_req;
    logic [15:0] ats_ctrlA;
    logic [15:0] ats_ctrlB;
    logic        ats_ready;
    logic [1:0]  ats_stat;
    logic [23:0] ats_data;
    logic        busy;

    modport slave (
        input  a_valid, a_ctrlA, a_ctrlB, b_valid, b_ctrlA, b_ctrlB,
        input  ats_ready, ats_stat, ats_data,
        output a_ready, b_ready,
        output a_rsp_valid, a_rsp_stat, a_rsp_data, a_rsp_timeout,
        output b_rsp_valid, b_rsp_stat, b_rsp_data, b_rsp_timeout,
        output ats_req, ats_ctrlA, ats_ctrlB, busy
    );

    modport master (
        output a_valid, a_ctrlA, a_ctrlB, b_valid, b_ctrlA, b_ctrlB,
        output ats_ready, ats_stat, ats_data,
        input  a_ready, b_ready,
        input  a_rsp_valid, a_rsp_stat, a_rsp_data, a_rsp_timeout,
        input  b_rsp_valid, b_rsp_stat, b_rsp_data, b_rsp_timeout,
        input  ats_req, ats_ctrlA, ats_ctrlB, busy
    );
endinterface

// File: rtl/ats21_cmd_arbiter.sv
// Two-client round-robin front end for the ATS21 command port: per-client FIFOs,
// one outstanding ATS21 handshake at a time, and a watchdog that turns a missing ready into a timeout.
module ats21_cmd_arbiter #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic                clk,
    input logic                reset,
    ats21_cmd_arbiter_if.slave bus
);
    localparam int unsigned   AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   PTR_ONE  = 1;
    localparam logic [7:0]    CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    logic [1:0]  in_valid;
    logic [31:0] in_cmd [2];
    logic [1:0]  full;
    logic [1:0]  empty;
    logic [1:0]  push;
    logic [1:0]  pop;
    logic [31:0] head [2];

    assign in_valid  = {bus.b_valid, bus.a_valid};
    assign in_cmd[0] = {bus.a_ctrlA, bus.a_ctrlB};
    assign in_cmd[1] = {bus.b_ctrlA, bus.b_ctrlB};

    // Index 0 is client A, index 1 is client B throughout.
    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [AW:0] wr_q;
        logic [AW:0] rd_q;
        logic [31:0] mem_q [FIFO_DEPTH];

        assign full[g]  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        assign empty[g] = (wr_q == rd_q);
        assign push[g]  = in_valid[g] && !full[g];
        assign head[g]  = mem_q[rd_q[AW-1:0]];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push[g]) wr_q <= wr_q + PTR_ONE;
                if (pop[g])  rd_q <= rd_q + PTR_ONE;
            end
        end

        always_ff @(posedge clk) begin
            if (push[g]) mem_q[wr_q[AW-1:0]] <= in_cmd[g];
        end
    end

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic [31:0] cmd_q, cmd_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cap;
    logic [1:0]  cap_stat;
    logic [23:0] cap_data;
    logic        cap_tmo;
    logic [1:0]  a_stat_q, b_stat_q;
    logic [23:0] a_data_q, b_data_q;
    logic        a_tmo_q, b_tmo_q;

    // grant_q doubles as last_grant: it keeps the previous winner while IDLE.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        pop      = '0;
        cap      = 1'b0;
        cap_stat = '0;
        cap_data = '0;
        cap_tmo  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty[0] && (empty[1] || grant_q)) begin
                    grant_d = 1'b0;
                    pop[0]  = 1'b1;
                    cmd_d   = head[0];
                    state_d = ISSUE;
                end else if (!empty[1]) begin
                    grant_d = 1'b1;
                    pop[1]  = 1'b1;
                    cmd_d   = head[1];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.ats_ready) begin
                    cap      = 1'b1;
                    cap_stat = bus.ats_stat;
                    cap_data = bus.ats_data;
                    state_d  = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cap     = 1'b1;
                    cap_tmo = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= 1'b1;
            cmd_q    <= '0;
            cnt_q    <= '0;
            a_stat_q <= '0;
            a_data_q <= '0;
            a_tmo_q  <= 1'b0;
            b_stat_q <= '0;
            b_data_q <= '0;
            b_tmo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            if (cap && !grant_q) begin
                a_stat_q <= cap_stat;
                a_data_q <= cap_data;
                a_tmo_q  <= cap_tmo;
            end
            if (cap && grant_q) begin
                b_stat_q <= cap_stat;
                b_data_q <= cap_data;
                b_tmo_q  <= cap_tmo;
            end
        end
    end

    assign bus.a_ready       = !full[0];
    assign bus.b_ready       = !full[1];
    assign bus.ats_req       = (state_q == ISSUE);
    assign bus.ats_ctrlA     = cmd_q[31:16];
    assign bus.ats_ctrlB     = cmd_q[15:0];
    assign bus.busy          = (state_q != IDLE);
    assign bus.a_rsp_valid   = (state_q == RESP) && !grant_q;
    assign bus.b_rsp_valid   = (state_q == RESP) && grant_q;
    assign bus.a_rsp_stat    = a_stat_q;
    assign bus.a_rsp_data    = a_data_q;
    assign bus.a_rsp_timeout = a_tmo_q;
    assign bus.b_rsp_stat    = b_stat_q;
    assign bus.b_rsp_data    = b_data_q;
    assign bus.b_rsp_timeout = b_tmo_q;
endmodule

// File: tb/tb_ats21_cmd_arbiter.sv
// Directed bench for ats21_cmd_arbiter: an ATS21 responder driven by a per-command plan,
// and a scoreboard of expected issues and responses checked as the DUT produces them.
module tb_ats21_cmd_arbiter;
    localparam int T      = 8;
    localparam int NEVER  = 1000;
    localparam int BUDGET = 300;

    typedef struct {int delay; logic [1:0] stat; logic [23:0] data;} plan_t;
    typedef struct {bit cl; logic [15:0] ca; logic [15:0] cb;} iss_t;
    typedef struct {logic [1:0] stat; logic [23:0] data; logic tmo; int lat;} rsp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ats21_cmd_arbiter_if bus();

    ats21_cmd_arbiter #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(T)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    req_cyc = 0;
    bit    cur_cl  = 1'b0;
    iss_t  exp_issue[$];
    rsp_t  exp_rsp_a[$];
    rsp_t  exp_rsp_b[$];
    plan_t plan[bit [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cmd(input bit cl, input logic [15:0] ca, input logic [15:0] cb,
                              input int d, input logic [1:0] st, input logic [23:0] dt,
                              input bit want_rsp);
        rsp_t r;
        plan[{ca, cb}] = '{d, st, dt};
        exp_issue.push_back('{cl, ca, cb});
        if (d >= 1 && d <= T) r = '{st, dt, 1'b0, d + 1};
        else                  r = '{2'b00, 24'h0, 1'b1, T + 1};
        if (want_rsp) begin
            if (cl) exp_rsp_b.push_back(r);
            else    exp_rsp_a.push_back(r);
        end
    endtask

    // Called at a negedge; returns at the negedge after the last acceptance.
    task automatic send(input bit do_a, input logic [15:0] aa, input logic [15:0] ab,
                        input bit do_b, input logic [15:0] ba, input logic [15:0] bb,
                        output int stalls);
        bit pa = do_a;
        bit pb = do_b;
        bit acc_a, acc_b;
        int n = 0;
        stalls = 0;
        while ((pa || pb) && n < BUDGET) begin
            bus.a_valid = pa; bus.a_ctrlA = aa; bus.a_ctrlB = ab;
            bus.b_valid = pb; bus.b_ctrlA = ba; bus.b_ctrlB = bb;
            acc_a = pa && bus.a_ready;
            acc_b = pb && bus.b_ready;
            if ((pa && !acc_a) || (pb && !acc_b)) stalls++;
            @(negedge clk);
            if (acc_a) pa = 1'b0;
            if (acc_b) pb = 1'b0;
            n++;
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        if (pa || pb) check("send_timeout", {30'b0, pa, pb}, 32'h0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_issue.size() != 0 || exp_rsp_a.size() != 0 || exp_rsp_b.size() != 0
                || bus.busy) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(n < BUDGET), 32'h1);
    endtask

    // ATS21 model: ready is raised `delay` cycles after the ats_req cycle.
    initial begin
        int    cnt;
        int    dly;
        bit    pend;
        plan_t p;
        pend = 1'b0;
        cnt  = 0;
        dly  = NEVER;
        forever begin
            @(negedge clk);
            bus.ats_ready = 1'b0;
            if (!reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cnt++;
                    if (cnt == dly) begin
                        bus.ats_ready = 1'b1;
                        bus.ats_stat  = p.stat;
                        bus.ats_data  = p.data;
                        pend = 1'b0;
                    end
                end
                if (bus.ats_req) begin
                    if (plan.exists({bus.ats_ctrlA, bus.ats_ctrlB})) p = plan[{bus.ats_ctrlA, bus.ats_ctrlB}];
                    else p = '{NEVER, 2'b00, 24'h0};
                    dly  = p.delay;
                    cnt  = 0;
                    pend = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (bus.ats_req) begin
                if (exp_issue.size() == 0) begin
                    check("unexpected_req", 32'(bus.ats_req), 32'h0);
                end else begin
                    iss_t e;
                    e = exp_issue.pop_front();
                    check("issue_ctrlA", 32'(bus.ats_ctrlA), 32'(e.ca));
                    check("issue_ctrlB", 32'(bus.ats_ctrlB), 32'(e.cb));
                    cur_cl  = e.cl;
                    req_cyc = cyc;
                end
            end
            if (bus.a_rsp_valid) begin
                if (exp_rsp_a.size() == 0) begin
                    check("unexpected_a_rsp", 32'(bus.a_rsp_valid), 32'h0);
                end else begin
                    rsp_t r;
                    r = exp_rsp_a.pop_front();
                    check("a_rsp_client",  32'h0, 32'(cur_cl));
                    check("a_rsp_stat",    32'(bus.a_rsp_stat), 32'(r.stat));
                    check("a_rsp_data",    32'(bus.a_rsp_data), 32'(r.data));
                    check("a_rsp_timeout", 32'(bus.a_rsp_timeout), 32'(r.tmo));
                    check("a_rsp_latency", 32'(cyc - req_cyc), 32'(r.lat));
                end
            end
            if (bus.b_rsp_valid) begin
                if (exp_rsp_b.size() == 0) begin
                    check("unexpected_b_rsp", 32'(bus.b_rsp_valid), 32'h0);
                end else begin
                    rsp_t r;
                    r = exp_rsp_b.pop_front();
                    check("b_rsp_client",  32'h1, 32'(cur_cl));
                    check("b_rsp_stat",    32'(bus.b_rsp_stat), 32'(r.stat));
                    check("b_rsp_data",    32'(bus.b_rsp_data), 32'(r.data));
                    check("b_rsp_timeout", 32'(bus.b_rsp_timeout), 32'(r.tmo));
                    check("b_rsp_latency", 32'(cyc - req_cyc), 32'(r.lat));
                end
            end
        end
    end

    initial begin
        int st;
        int wait_n;
        reset = 1'b0;
        bus.a_valid = 1'b0; bus.a_ctrlA = '0; bus.a_ctrlB = '0;
        bus.b_valid = 1'b0; bus.b_ctrlA = '0; bus.b_ctrlB = '0;
        bus.ats_ready = 1'b0; bus.ats_stat = '0; bus.ats_data = '0;
        repeat (3) @(negedge clk);
        check("rst_a_ready",     32'(bus.a_ready), 32'h1);
        check("rst_b_ready",     32'(bus.b_ready), 32'h1);
        check("rst_busy",        32'(bus.busy), 32'h0);
        check("rst_ats_req",     32'(bus.ats_req), 32'h0);
        check("rst_a_rsp_valid", 32'(bus.a_rsp_valid), 32'h0);
        check("rst_ats_ctrlA",   32'(bus.ats_ctrlA), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Contention from reset: A wins first, then strict alternation.
        expect_cmd(0, 16'hA001, 16'h0102, 2, 2'b10, 24'hA1A1A1, 1);
        expect_cmd(1, 16'hB001, 16'h0201, 1, 2'b11, 24'hB1B1B1, 1);
        expect_cmd(0, 16'hA002, 16'h0103, 3, 2'b00, 24'hA2A2A2, 1);
        expect_cmd(1, 16'hB002, 16'h0202, 5, 2'b01, 24'hB2B2B2, 1);
        send(1, 16'hA001, 16'h0102, 1, 16'hB001, 16'h0201, st);
        send(1, 16'hA002, 16'h0103, 1, 16'hB002, 16'h0202, st);
        wait_drain();

        // Single command with issue-latency check.
        expect_cmd(0, 16'h1234, 16'h0005, 3, 2'b01, 24'h00000F, 1);
        send(1, 16'h1234, 16'h0005, 0, 16'h0, 16'h0, st);
        check("t1_req_early", 32'(bus.ats_req), 32'h0);
        @(negedge clk);
        check("t1_req",  32'(bus.ats_req), 32'h1);
        check("t1_busy", 32'(bus.busy), 32'h1);
        wait_drain();
        check("t1_idle", 32'(bus.busy), 32'h0);

        // FIFO full: first command stalls the ATS21 side, five get accepted.
        for (int i = 1; i <= 6; i++)
            expect_cmd(0, 16'hC000 + 16'(i), 16'h0010 + 16'(i), (i == 1) ? NEVER : i,
                       2'(i), 24'h0000C0 + 24'(i), 1);
        for (int i = 1; i <= 5; i++)
            send(1, 16'hC000 + 16'(i), 16'h0010 + 16'(i), 0, 16'h0, 16'h0, st);
        check("t3_full", 32'(bus.a_ready), 32'h0);
        send(1, 16'hC006, 16'h0016, 0, 16'h0, 16'h0, wait_n);
        check("t3_held", 32'(wait_n > 0), 32'h1);
        wait_drain();

        // Timeout, then a normal command behind it.
        expect_cmd(0, 16'h4001, 16'h0040, NEVER, 2'b11, 24'hFFFFFF, 1);
        expect_cmd(0, 16'h4002, 16'h0041, 4, 2'b10, 24'h440044, 1);
        send(1, 16'h4001, 16'h0040, 0, 16'h0, 16'h0, st);
        send(1, 16'h4002, 16'h0041, 0, 16'h0, 16'h0, st);
        wait_drain();

        // Ready on the final timeout cycle wins.
        expect_cmd(1, 16'h5001, 16'h0050, T, 2'b11, 24'h55AA55, 1);
        send(0, 16'h0, 16'h0, 1, 16'h5001, 16'h0050, st);
        wait_drain();

        // Reset during WAIT with two commands queued.
        expect_cmd(0, 16'h6001, 16'h0060, NEVER, 2'b00, 24'h0, 0);
        send(1, 16'h6001, 16'h0060, 0, 16'h0, 16'h0, st);
        send(1, 16'h6003, 16'h0062, 1, 16'h6002, 16'h0061, st);
        wait_n = 0;
        while (exp_issue.size() != 0 && wait_n < BUDGET) begin
            @(negedge clk);
            wait_n++;
        end
        check("t6_issued", 32'(exp_issue.size()), 32'h0);
        repeat (2) @(negedge clk);
        check("t6_busy_pre", 32'(bus.busy), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("t6_busy",        32'(bus.busy), 32'h0);
        check("t6_ats_req",     32'(bus.ats_req), 32'h0);
        check("t6_ats_ctrlA",   32'(bus.ats_ctrlA), 32'h0);
        check("t6_a_rsp_valid", 32'(bus.a_rsp_valid), 32'h0);
        check("t6_b_rsp_valid", 32'(bus.b_rsp_valid), 32'h0);
        check("t6_a_rsp_stat",  32'(bus.a_rsp_stat), 32'h0);
        check("t6_b_rsp_data",  32'(bus.b_rsp_data), 32'h0);
        check("t6_a_ready",     32'(bus.a_ready), 32'h1);
        check("t6_b_ready",     32'(bus.b_ready), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("t6_fifo_empty", 32'(bus.busy), 32'h0);
        check("t6_no_rsp",     32'(exp_rsp_a.size() + exp_rsp_b.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
